// File: rtl/dot_product_sequencer_if.sv
// Handshake, operand-memory and ALU bus of the dot-product sequencer.
// master = sequencer side, slave = environment (memories, ALU, host).
interface dot_product_sequencer_if;
   logic        start;
   logic [7:0]  len;
   logic [7:0]  addr;
   logic [15:0] a_data;
   logic [15:0] b_data;
   logic [2:0]  alu_control;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [15:0] alu_out;
   logic        alu_zflag;
   logic        busy;
   logic        done;
   logic [15:0] result;

   modport master (
      input  start, len, a_data, b_data,
      input  alu_out, alu_zflag,
      output addr, alu_control, alu_in1, alu_in2,
      output busy, done, result
   );

   modport slave (
      output start, len, a_data, b_data,
      output alu_out, alu_zflag,
      input  addr, alu_control, alu_in1, alu_in2,
      input  busy, done, result
   );
endinterface

// File: rtl/dot_product_sequencer.sv
// Sequences an external registered ALU to compute sum(a[i]*b[i]) mod 2^16.
// Each element costs 7 cycles: load, mul, wait, add, wait, decrement, wait.
module dot_product_sequencer #(
   parameter logic [2:0] OP_NOP = 3'b000,
   parameter logic [2:0] OP_MUL = 3'b001,
   parameter logic [2:0] OP_ADD = 3'b010,
   parameter logic [2:0] OP_SUB = 3'b011
) (
   input  logic                    clk,
   input  logic                    rst_n,
   dot_product_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, LOAD, MUL, MWAIT, ADD, AWAIT, DEC, DWAIT, DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_idx;
   logic [15:0] r_cnt;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_prod;
   logic [15:0] r_acc;
   logic [15:0] r_result;
   logic [15:0] r_in1;
   logic [15:0] r_in2;
   logic [2:0]  w_op;
   logic [15:0] w_in1;
   logic [15:0] w_in2;
   logic        w_busy;
   logic        w_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_op   = OP_NOP;
      w_in1  = r_in1;
      w_in2  = r_in2;
      w_busy = 1'b1;
      w_done = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (bus.start)
               w_next = (bus.len == 8'd0) ? DONE : LOAD;
         end
         LOAD:  w_next = MUL;
         MUL: begin
            w_op   = OP_MUL;
            w_in1  = r_a;
            w_in2  = r_b;
            w_next = MWAIT;
         end
         MWAIT: w_next = ADD;
         ADD: begin
            w_op   = OP_ADD;
            w_in1  = r_acc;
            w_in2  = r_prod;
            w_next = AWAIT;
         end
         AWAIT: w_next = DEC;
         DEC: begin
            w_op   = OP_SUB;
            w_in1  = r_cnt;
            w_in2  = 16'd1;
            w_next = DWAIT;
         end
         DWAIT: w_next = bus.alu_zflag ? DONE : LOAD;
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand registers keep the last issued pair outside issue states
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= 8'd0;
         r_cnt    <= 16'd0;
         r_a      <= 16'd0;
         r_b      <= 16'd0;
         r_prod   <= 16'd0;
         r_acc    <= 16'd0;
         r_result <= 16'd0;
         r_in1    <= 16'd0;
         r_in2    <= 16'd0;
      end else begin
         r_in1 <= w_in1;
         r_in2 <= w_in2;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_cnt <= {8'b0, bus.len};
                  r_idx <= 8'd0;
                  r_acc <= 16'd0;
                  if (bus.len == 8'd0) r_result <= 16'd0;
               end
            end
            LOAD: begin
               r_a <= bus.a_data;
               r_b <= bus.b_data;
            end
            MWAIT: r_prod <= bus.alu_out;
            AWAIT: r_acc  <= bus.alu_out;
            DWAIT: begin
               r_cnt <= bus.alu_out;
               r_idx <= r_idx + 8'd1;
               if (bus.alu_zflag) r_result <= r_acc;
            end
            default: ;
         endcase
      end
   end

   assign bus.addr        = r_idx;
   assign bus.alu_control = w_op;
   assign bus.alu_in1     = w_in1;
   assign bus.alu_in2     = w_in2;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.result      = r_result;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer with a behavioural team ALU responder.
// Expected sums, latency and traces come from a per-element timing model.
module tb_dot_product_sequencer;

   localparam logic [2:0] NOP = 3'b000;
   localparam logic [2:0] MULC = 3'b001;
   localparam logic [2:0] ADDC = 3'b010;
   localparam logic [2:0] SUBC = 3'b011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dot_product_sequencer_if bus();

   dot_product_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   assign bus.a_data = mem_a[bus.addr];
   assign bus.b_data = mem_b[bus.addr];

   // team ALU: registered result and zero flag, hold on NOP
   logic [15:0] alu_r;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alu_out   <= 16'd0;
         bus.alu_zflag <= 1'b0;
      end else begin
         alu_r = 16'd0;
         case (bus.alu_control)
            MULC: alu_r = bus.alu_in1 * bus.alu_in2;
            ADDC: alu_r = bus.alu_in1 + bus.alu_in2;
            SUBC: alu_r = bus.alu_in1 - bus.alu_in2;
            default: alu_r = bus.alu_out;
         endcase
         if (bus.alu_control != NOP) begin
            bus.alu_out   <= alu_r;
            bus.alu_zflag <= (alu_r == 16'd0);
         end
      end
   end

   int checks = 0;
   int failures = 0;

   logic [2:0]  tr_op [$];
   logic [7:0]  tr_addr [$];
   logic        tr_busy [$];
   logic [15:0] tr_in1 [$];
   logic [15:0] tr_in2 [$];
   int done_cyc;
   int n_done;
   int rp1 = -1;
   int rp2 = -1;

   function automatic logic [15:0] model_dot(int n);
      int unsigned s = 0;
      for (int i = 0; i < n; i++)
         s = (s + mem_a[i] * mem_b[i]) & 32'hFFFF;
      return s[15:0];
   endfunction

   function automatic int model_lat(int n);
      return (n == 0) ? 1 : 7 * n + 1;
   endfunction

   // opcode expected in cycle k (1-based after accept edge)
   function automatic logic [2:0] exp_op(int k, int n);
      if (k > 7 * n) return NOP;
      case ((k - 1) % 7)
         1: return MULC;
         3: return ADDC;
         5: return SUBC;
         default: return NOP;
      endcase
   endfunction

   task automatic run_op(input int n);
      int lim;
      tr_op.delete(); tr_addr.delete(); tr_busy.delete();
      tr_in1.delete(); tr_in2.delete();
      done_cyc = -1;
      n_done = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len = n[7:0];
      @(posedge clk);
      lim = 7 * n + 20;
      for (int k = 1; k <= lim; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.len = 8'($urandom);
         tr_op.push_back(bus.alu_control);
         tr_addr.push_back(bus.addr);
         tr_busy.push_back(bus.busy);
         tr_in1.push_back(bus.alu_in1);
         tr_in2.push_back(bus.alu_in2);
         if (bus.done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (k == rp1 || k == rp2) bus.start = 1'b1;
         if (done_cyc >= 0 && k >= done_cyc + 2) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b1;
      bus.len = 8'd5;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.alu_control !== NOP) begin
         failures++;
         $display("FAIL reset_ctrl busy=%b done=%b op=%b want 0 0 000",
                  bus.busy, bus.done, bus.alu_control);
      end
      checks++;
      if (bus.result !== 16'd0 || bus.addr !== 8'd0 ||
          bus.alu_in1 !== 16'd0 || bus.alu_in2 !== 16'd0) begin
         failures++;
         $display("FAIL reset_data result=%h addr=%h in1=%h in2=%h want 0",
                  bus.result, bus.addr, bus.alu_in1, bus.alu_in2);
      end
      bus.start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_len0();
      int bad = 0;
      run_op(0);
      checks++;
      if (done_cyc !== 1 || n_done !== 1) begin
         failures++;
         $display("FAIL len0_latency got cyc=%0d n=%0d want 1 1",
                  done_cyc, n_done);
      end
      checks++;
      if (bus.result !== 16'h0000) begin
         failures++;
         $display("FAIL len0_result got %h want 0000", bus.result);
      end
      foreach (tr_op[i]) if (tr_op[i] !== NOP) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL len0_opcode got %0d non-NOP cycles want 0", bad);
      end
   endtask

   task automatic test_basic();
      int bad_op = 0;
      int bad_ad = 0;
      for (int i = 0; i < 3; i++) begin
         mem_a[i] = 16'(i + 1);
         mem_b[i] = 16'(i + 4);
      end
      run_op(3);
      checks++;
      if (done_cyc !== 22 || n_done !== 1) begin
         failures++;
         $display("FAIL basic_latency got cyc=%0d n=%0d want 22 1",
                  done_cyc, n_done);
      end
      checks++;
      if (bus.result !== 16'h0020) begin
         failures++;
         $display("FAIL basic_result got %h want 0020", bus.result);
      end
      for (int k = 1; k <= 22 && k <= tr_op.size(); k++) begin
         if (tr_op[k-1] !== exp_op(k, 3)) bad_op++;
         if (tr_addr[k-1] !== 8'((k - 1) / 7)) bad_ad++;
      end
      checks++;
      if (bad_op !== 0 || bad_ad !== 0) begin
         failures++;
         $display("FAIL basic_trace got op_err=%0d addr_err=%0d want 0 0",
                  bad_op, bad_ad);
      end
   endtask

   task automatic test_trunc();
      mem_a[0] = 16'h0100;
      mem_b[0] = 16'h0100;
      run_op(1);
      checks++;
      if (bus.result !== 16'h0000 || done_cyc !== 8) begin
         failures++;
         $display("FAIL trunc got result=%h cyc=%0d want 0000 8",
                  bus.result, done_cyc);
      end
   endtask

   task automatic test_wrap();
      mem_a[0] = 16'hFFFF; mem_b[0] = 16'h0001;
      mem_a[1] = 16'h0001; mem_b[1] = 16'h0001;
      run_op(2);
      checks++;
      if (bus.result !== 16'h0000 || done_cyc !== 15) begin
         failures++;
         $display("FAIL wrap got result=%h cyc=%0d want 0000 15",
                  bus.result, done_cyc);
      end
   endtask

   task automatic test_restart();
      int bad = 0;
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = 16'($urandom);
         mem_b[i] = 16'($urandom);
      end
      rp1 = 3;
      rp2 = 10;
      run_op(4);
      rp1 = -1;
      rp2 = -1;
      checks++;
      if (done_cyc !== 29 || n_done !== 1) begin
         failures++;
         $display("FAIL restart_done got cyc=%0d n=%0d want 29 1",
                  done_cyc, n_done);
      end
      foreach (tr_busy[i])
         if (tr_busy[i] !== ((i + 1) <= 29)) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL restart_busy got %0d bad cycles want 0", bad);
      end
      checks++;
      if (bus.result !== model_dot(4)) begin
         failures++;
         $display("FAIL restart_result got %h want %h",
                  bus.result, model_dot(4));
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         int n = $urandom_range(1, 12);
         int bad = 0;
         for (int i = 0; i < n; i++) begin
            mem_a[i] = (r % 3 == 0) ? 16'($urandom_range(0, 15))
                                    : 16'($urandom);
            mem_b[i] = 16'($urandom);
         end
         run_op(n);
         checks++;
         if (bus.result !== model_dot(n)) begin
            failures++;
            $display("FAIL rand_result run=%0d n=%0d got %h want %h",
                     r, n, bus.result, model_dot(n));
         end
         checks++;
         if (done_cyc !== model_lat(n) || n_done !== 1) begin
            failures++;
            $display("FAIL rand_latency run=%0d got cyc=%0d n=%0d want %0d 1",
                     r, done_cyc, n_done, model_lat(n));
         end
         for (int k = 1; k <= 7 * n && k <= tr_op.size(); k++) begin
            int e = (k - 1) / 7;
            if (tr_op[k-1] !== exp_op(k, n)) bad++;
            if (tr_addr[k-1] !== 8'(e)) bad++;
            if ((k - 1) % 7 == 1 &&
                (tr_in1[k-1] !== mem_a[e] || tr_in2[k-1] !== mem_b[e]))
               bad++;
            if ((k - 1) % 7 == 5 &&
                (tr_in1[k-1] !== 16'(n - e) || tr_in2[k-1] !== 16'd1))
               bad++;
         end
         checks++;
         if (bad !== 0) begin
            failures++;
            $display("FAIL rand_trace run=%0d n=%0d got %0d errors want 0",
                     r, n, bad);
         end
      end
   endtask

   task automatic test_reset_midop();
      int dn = 0;
      mem_a[0] = 16'h0003; mem_b[0] = 16'h0005;
      mem_a[1] = 16'h0002; mem_b[1] = 16'h0009;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len = 8'd2;
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) dn++;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'd0 ||
          bus.addr !== 8'd0 || bus.alu_in1 !== 16'd0 ||
          bus.alu_in2 !== 16'd0 || bus.alu_control !== NOP) begin
         failures++;
         $display("FAIL midop_clear busy=%b done=%b res=%h addr=%h in=%h/%h",
                  bus.busy, bus.done, bus.result, bus.addr,
                  bus.alu_in1, bus.alu_in2);
      end
      repeat (3) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      checks++;
      if (dn !== 0) begin
         failures++;
         $display("FAIL midop_nodone got %0d done pulses want 0", dn);
      end
      mem_a[0] = 16'd7;
      mem_b[0] = 16'd7;
      run_op(1);
      checks++;
      if (bus.result !== 16'h0031 || done_cyc !== 8) begin
         failures++;
         $display("FAIL midop_rerun got result=%h cyc=%0d want 0031 8",
                  bus.result, done_cyc);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'd0;
         mem_b[i] = 16'd0;
      end
      bus.start = 1'b0;
      bus.len = 8'd0;
      test_reset();
      test_len0();
      test_basic();
      test_trunc();
      test_wrap();
      test_restart();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
